// File: rtl/ext_pipe_pkg.sv
// Shared control encodings for the immediate / load-data extender.
package ext_pipe_pkg;

    typedef logic [2:0] ext_op_t;

    // Codes 0..2 are inherited from the original combinational extender.
    localparam ext_op_t EXT_ZERO       = 3'd0;
    localparam ext_op_t EXT_SIGNED     = 3'd1;
    localparam ext_op_t EXT_HIGHPOS    = 3'd2;
    localparam ext_op_t EXT_SIGNED_SL2 = 3'd3;
    localparam ext_op_t EXT_LB         = 3'd4;
    localparam ext_op_t EXT_LBU        = 3'd5;
    localparam ext_op_t EXT_LH         = 3'd6;
    localparam ext_op_t EXT_LHU        = 3'd7;

    // Halfword loads are the only ops that care about alignment.
    function automatic logic ext_is_half(input ext_op_t op);
        return (op == EXT_LH) || (op == EXT_LHU);
    endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational extender: immediate modes and byte/halfword extraction from a load word.
module ext_core
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int OFF_W = 2
) (
    input  logic [2:0]       op_i,
    input  logic [IN_W-1:0]  imm_i,
    input  logic [OUT_W-1:0] data_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [OUT_W-1:0] data_o,
    output logic             err_o
);

    logic [OUT_W-1:0] sext;
    logic [OFF_W-1:0] off_p1;
    logic [7:0]       lo_byte;
    logic [7:0]       hi_byte;
    logic [15:0]      half;

    assign sext    = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
    // The upper halfword byte wraps for off = max, but that offset is always
    // odd and therefore rejected as misaligned before it is used.
    assign off_p1  = off_i + OFF_W'(1);
    assign lo_byte = data_i[{off_i, 3'b000} +: 8];
    assign hi_byte = data_i[{off_p1, 3'b000} +: 8];
    assign half    = {hi_byte, lo_byte};

    // Select the extension for the requested op; misaligned halfwords yield zero plus error.
    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        if (ext_is_half(op_i) && off_i[0]) begin
            err_o = 1'b1;
        end else begin
            case (op_i)
                EXT_ZERO:       data_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
                EXT_SIGNED:     data_o = sext;
                EXT_HIGHPOS:    data_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
                EXT_SIGNED_SL2: data_o = sext << 2;
                EXT_LB:         data_o = {{(OUT_W-8){lo_byte[7]}}, lo_byte};
                EXT_LBU:        data_o = {{(OUT_W-8){1'b0}}, lo_byte};
                EXT_LH:         data_o = {{(OUT_W-16){half[15]}}, half};
                EXT_LHU:        data_o = {{(OUT_W-16){1'b0}}, half};
                default:        data_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined extender: ext_core feeding an output register with a one-entry skid buffer.
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int OFF_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OUT_W-1:0] in_data,
    input  logic [OFF_W-1:0] in_off,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    logic [OUT_W-1:0] core_data;
    logic             core_err;

    logic             or_valid_q, or_valid_d;
    logic [OUT_W-1:0] or_data_q,  or_data_d;
    logic             or_err_q,   or_err_d;
    logic             sk_valid_q, sk_valid_d;
    logic [OUT_W-1:0] sk_data_q,  sk_data_d;
    logic             sk_err_q,   sk_err_d;
    logic             in_ready_q, in_ready_d;
    logic             acc;
    logic             pop;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .OFF_W (OFF_W)
    ) u_core (
        .op_i   (in_op),
        .imm_i  (in_imm),
        .data_i (in_data),
        .off_i  (in_off),
        .data_o (core_data),
        .err_o  (core_err)
    );

    assign acc = in_valid && in_ready_q;
    assign pop = or_valid_q && out_ready;

    // Next-state for the output register and skid entry; the skid drains before new input lands.
    always_comb begin
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        or_err_d   = or_err_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_err_d   = sk_err_q;
        if (sk_valid_q) begin
            // in_ready is low here, so acc cannot occur alongside the skid move.
            if (pop) begin
                or_data_d  = sk_data_q;
                or_err_d   = sk_err_q;
                sk_valid_d = 1'b0;
            end
        end else if (!or_valid_q || pop) begin
            or_valid_d = acc;
            if (acc) begin
                or_data_d = core_data;
                or_err_d  = core_err;
            end
        end else if (acc) begin
            sk_valid_d = 1'b1;
            sk_data_d  = core_data;
            sk_err_d   = core_err;
        end
        in_ready_d = !sk_valid_d;
    end

    // Pipeline registers; reset drops everything in flight and holds in_ready low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            or_err_q   <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
            sk_err_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_err_q   <= or_err_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
            sk_err_q   <= sk_err_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = or_valid_q;
    assign out_data  = or_data_q;
    assign out_err   = or_err_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: directed modes, backpressure, random handshake, reset mid-stream.
module tb_ext_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int OFF_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [15:0] in_imm = '0;
    logic [31:0] in_data = '0;
    logic [1:0]  in_off = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    ext_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .OFF_W (OFF_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_imm    (in_imm),
        .in_data   (in_data),
        .in_off    (in_off),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    // Reference model: {err, data}
    function automatic logic [32:0] ref_ext(input logic [2:0] op, input logic [15:0] imm,
                                            input logic [31:0] d, input logic [1:0] off);
        logic [31:0] s;
        logic [31:0] sh;
        s  = {{16{imm[15]}}, imm};
        sh = d >> (off * 8);
        case (op)
            3'd0: return {1'b0, 16'h0000, imm};
            3'd1: return {1'b0, s};
            3'd2: return {1'b0, imm, 16'h0000};
            3'd3: return {1'b0, s[29:0], 2'b00};
            3'd4: return {1'b0, {24{sh[7]}}, sh[7:0]};
            3'd5: return {1'b0, 24'h000000, sh[7:0]};
            3'd6: return off[0] ? {1'b1, 32'h0} : {1'b0, {16{sh[15]}}, sh[15:0]};
            default: return off[0] ? {1'b1, 32'h0} : {1'b0, 16'h0000, sh[15:0]};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out got valid=%b data=%h err=%b exp 0/0/0", out_valid, out_data, out_err);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_low got=%b exp=0", in_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle got valid=%b data=%h exp 0/0", out_valid, out_data);
        end
    endtask

    task automatic test_imm_modes();
        logic [31:0] exp_tab [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
        logic [32:0] exp;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_op    = k[2:0];
            in_imm   = 16'h8001;
            in_data  = $urandom;
            in_off   = 2'($urandom_range(0, 3));
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL imm_ready op=%0d got=%b exp=1", k, in_ready);
            end
            sb_q.push_back({1'b0, exp_tab[k]});
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL imm_latency op=%0d out_valid=%b exp=1", k, out_valid);
            end else begin
                exp = sb_q.pop_front();
                if ({out_err, out_data} !== exp) begin
                    n_fail++;
                    $display("FAIL imm_mode op=%0d got=%b/%h exp=%b/%h", k, out_err, out_data, exp[32], exp[31:0]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_drain out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_load_modes();
        logic [2:0]  op_tab  [7] = '{3'd4, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd7};
        logic [1:0]  off_tab [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
        logic [31:0] dat_tab [7] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                                     32'h00007F01, 32'h00000000, 32'h00000000};
        logic        err_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [32:0] exp;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_op    = op_tab[k];
            in_off   = off_tab[k];
            in_data  = 32'h80FF7F01;
            in_imm   = 16'($urandom);
            sb_q.push_back({err_tab[k], dat_tab[k]});
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL load_latency idx=%0d out_valid=%b exp=1", k, out_valid);
            end else begin
                exp = sb_q.pop_front();
                if ({out_err, out_data} !== exp) begin
                    n_fail++;
                    $display("FAIL load_mode op=%0d off=%0d got=%b/%h exp=%b/%h",
                             op_tab[k], off_tab[k], out_err, out_data, exp[32], exp[31:0]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [32:0] exp;
        int          rcvd;
        bit          sent3;
        out_ready = 1'b0;
        in_op     = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_imm   = 16'(k);
            n_checks++;
            if (in_ready !== (k < 3)) begin
                n_fail++;
                $display("FAIL bp_in_ready req=%0d got=%b exp=%b", k, in_ready, (k < 3));
            end
            if (k < 3) begin
                if (in_valid && in_ready) sb_q.push_back({1'b0, 32'(k)});
                @(posedge clk);
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        rcvd  = 0;
        sent3 = 1'b0;
        for (int cyc = 0; cyc < 20 && (rcvd < 3); cyc++) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra_output got=%h exp=none", out_data);
                end else begin
                    exp = sb_q.pop_front();
                    if ({out_err, out_data} !== exp) begin
                        n_fail++;
                        $display("FAIL bp_order got=%h exp=%h", out_data, exp[31:0]);
                    end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({1'b0, 32'd3});
                sent3 = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (sent3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++;
        if (rcvd != 3 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count got=%0d left=%0d exp=3/0", rcvd, sb_q.size());
        end
    endtask

    task automatic test_random();
        logic [32:0] exp;
        logic [31:0] held_data;
        logic        held_err;
        bit          have_req;
        bit          stalled;
        int          sent;
        int          rcvd;
        int          cyc;
        have_req = 1'b0;
        stalled  = 1'b0;
        sent     = 0;
        rcvd     = 0;
        cyc      = 0;
        held_data = '0;
        held_err  = 1'b0;
        sb_q.delete();
        while (rcvd < 1000 && cyc < 20000) begin
            if (!have_req && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_op    = 3'($urandom_range(0, 7));
                in_imm   = 16'($urandom);
                in_data  = $urandom;
                in_off   = 2'($urandom_range(0, 3));
                have_req = 1'b1;
            end
            in_valid  = have_req;
            out_ready = ($urandom_range(0, 2) != 0);
            if (stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_err !== held_err) begin
                    n_fail++;
                    $display("FAIL rand_stall_stable got=%b/%h exp=%b/%h", out_err, out_data, held_err, held_data);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra_output got=%h exp=none", out_data);
                end else begin
                    exp = sb_q.pop_front();
                    if ({out_err, out_data} !== exp) begin
                        n_fail++;
                        $display("FAIL rand_data idx=%0d got=%b/%h exp=%b/%h", rcvd, out_err, out_data, exp[32], exp[31:0]);
                    end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_ext(in_op, in_imm, in_data, in_off));
                have_req = 1'b0;
                sent++;
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_err  = out_err;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (rcvd != 1000 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count got=%0d left=%0d exp=1000/0", rcvd, sb_q.size());
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        for (int k = 0; k < 2; k++) begin
            in_imm = 16'(16'h00A0 + k);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_full got valid=%b ready=%b exp 1/0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_reset got valid=%b data=%h ready=%b exp 0/0/0", out_valid, out_data, in_ready);
        end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale cyc=%0d got valid=%b data=%h exp valid=0", k, out_valid, out_data);
            end
        end
        in_valid = 1'b1;
        in_op    = 3'd1;
        in_imm   = 16'hFFF0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFF0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fresh got valid=%b data=%h exp 1/fffffff0", out_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_imm_modes();
        test_load_modes();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender.
- Extends an immediate field (zero, sign, high-position, sign-and-shift-left-2) or extracts and extends a byte or halfword from a load word at a byte offset.
- Sits between decode/memory-read and ALU/writeback.
- Uses a valid/ready handshake with a registered output and a one-entry skid buffer, so `in_ready` comes straight from a flop.

Parameters:
- IN_W, 16, width of the immediate input; must be less than OUT_W.
- OUT_W, 32, datapath width; must be a multiple of 16 and at least 32.
- OFF_W, 2, byte-offset width; equals log2(OUT_W/8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  3  extension mode (encodings below).
- in_imm  in  IN_W  immediate operand (modes 0-3).
- in_data  in  OUT_W  load word (modes 4-7), little-endian bytes.
- in_off  in  OFF_W  byte offset into in_data (modes 4-7).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  OUT_W  extended result.
- out_err  out  1  result flags a misaligned halfword access.

Behaviour:
- Op encodings:
  - 0 EXT_ZERO: zero-extend in_imm.
  - 1 EXT_SIGNED: sign-extend in_imm.
  - 2 EXT_HIGHPOS: in_imm << (OUT_W-IN_W), low bits zero.
  - 3 EXT_SIGNED_SL2: sign-extend in_imm, then << 2; top bits drop.
  - 4 EXT_LB: sign-extend byte in_data[8*off +: 8].
  - 5 EXT_LBU: zero-extend the same byte.
  - 6 EXT_LH: sign-extend halfword in_data[8*off +: 16].
  - 7 EXT_LHU: zero-extend the same halfword.
- Misaligned halfword: for op 6/7 with in_off[0]=1, out_data=0 and out_err=1. For all other cases out_err=0.
- Unused inputs (in_data/in_off for ops 0-3, in_imm for ops 4-7) are ignored.
- Reset, asynchronous, any time including mid-transfer:
  - out_valid=0, out_data=0, out_err=0.
  - Skid entry cleared; all in-flight results discarded.
  - in_ready=0 while rst is high, 1 on the first edge after release.
- Latency: a result accepted at edge N is visible on out_* after edge N (1 cycle), if the output stage is free.
- Storage: output register (OR) plus skid register (SK). in_ready = !SK.valid, registered.
- On each edge, let acc = in_valid && in_ready and pop = out_valid && out_ready:
  - OR empty or pop, SK empty: acc loads OR; no acc with pop empties OR.
  - OR full, no pop, acc: result goes to SK; in_ready drops next cycle.
  - pop with SK full: SK moves to OR and SK empties; in_ready=0 that cycle, so no simultaneous acc.
  - Simultaneous acc and pop with SK empty: new result replaces OR; out_valid stays 1.
- Ordering is strictly FIFO. Results are never dropped or duplicated.
- out_data/out_err hold stable while out_valid && !out_ready.
- Sustained throughput is 1 result/cycle when out_ready is held high.

Decomposition:
- EXT_* op encodings (3-bit) go in the shared control-encoding define header, alongside the existing EXT_ZERO/EXT_SIGNED/EXT_HIGHPOS values, which keep codes 0/1/2.
- One combinational sub-module, ext_core (params IN_W, OUT_W, OFF_W), computes data/err from op/imm/data/off.
- ext_pipe instantiates ext_core and owns the OR/SK handshake logic.

Test Plan:
- Reset then idle: out_valid=0, out_data=0, in_ready=1 one cycle after rst falls.
- out_ready=1, ops 0..3 with imm=16'h8001: out_data = 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, each 1 cycle after accept.
- Load modes, in_data=32'h80FF7F01:
  - LB off1 -> 32'h0000007F; LB off2 -> 32'hFFFFFFFF; LBU off3 -> 32'h00000080.
  - LH off2 -> 32'hFFFF80FF; LHU off0 -> 32'h00007F01.
  - LH off1 -> out_data=0, out_err=1.
- Backpressure: out_ready=0, send 3 requests (imm 1,2,3): first two accepted, in_ready=0 on the third. Raise out_ready: outputs 1,2,3 in order, no loss.
- Random valid/ready toggling, 1000 ops against a reference model: exact in-order match, and out_data stable while stalled.
- Assert rst mid-stream with OR and SK both full: out_valid=0 immediately, no stale result after release.
